// File: rtl/mem_file_arbiter.sv
// Round-robin arbiter between two requesters for a single-port data memory,
// with a clear sequencer that zero-fills the memory while stalling both ports.
module mem_file_arbiter #(
  parameter int N_WORDS = 64,
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              mem_w_en,
  output logic [DATA_W-1:0] mem_w_data,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_r_data
);

  typedef enum logic {S_IDLE, S_CLEAR} state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                last_grant_q, last_grant_d;  // 0 = port 0, 1 = port 1
  logic                clr_done_q, clr_done_d;
  logic                rsp0_valid_q, rsp0_valid_d;
  logic                rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0]   rsp0_rdata_q, rsp0_rdata_d;
  logic [DATA_W-1:0]   rsp1_rdata_q, rsp1_rdata_d;
  logic                grant0, grant1;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    clr_done_d   = 1'b0;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    rsp0_rdata_d = rsp0_rdata_q;
    rsp1_rdata_d = rsp1_rdata_q;
    grant0       = 1'b0;
    grant1       = 1'b0;
    clr_busy     = 1'b0;
    mem_w_en     = 1'b0;
    mem_addr     = '0;
    mem_w_data   = '0;

    if (!reset) begin
      case (state_q)
        S_IDLE: begin
          if (clr_start) begin
            state_d = S_CLEAR;
          end else if (req0_valid && (!req1_valid || last_grant_q)) begin
            grant0 = 1'b1;
          end else if (req1_valid) begin
            grant1 = 1'b1;
          end
        end
        S_CLEAR: begin
          clr_busy = 1'b1;
          mem_w_en = 1'b1;
          mem_addr = cnt_q;
          cnt_d    = cnt_q + ADDR_W'(1);
          if (cnt_q == LAST_ADDR) begin
            cnt_d      = '0;
            state_d    = S_IDLE;
            clr_done_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // The granted port drives the memory; reads capture r_data at the accept edge.
    if (grant0) begin
      mem_w_en     = req0_we;
      mem_addr     = req0_addr;
      mem_w_data   = req0_wdata;
      last_grant_d = 1'b0;
      if (!req0_we) begin
        rsp0_valid_d = 1'b1;
        rsp0_rdata_d = mem_r_data;
      end
    end else if (grant1) begin
      mem_w_en     = req1_we;
      mem_addr     = req1_addr;
      mem_w_data   = req1_wdata;
      last_grant_d = 1'b1;
      if (!req1_we) begin
        rsp1_valid_d = 1'b1;
        rsp1_rdata_d = mem_r_data;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      clr_done_q   <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      clr_done_q   <= clr_done_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_rdata = rsp0_rdata_q;
  assign rsp1_rdata = rsp1_rdata_q;
  assign clr_done   = clr_done_q;

endmodule

// File: tb/tb_mem_file_arbiter.sv
// Directed bench for mem_file_arbiter: behavioural memory, reference memory model
// and per-port expected-read-data queues checked when responses appear.
module tb_mem_file_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req0_we;
  logic [5:0]  req0_addr;
  logic [31:0] req0_wdata;
  logic        rsp0_valid;
  logic [31:0] rsp0_rdata;
  logic        req1_valid, req1_ready, req1_we;
  logic [5:0]  req1_addr;
  logic [31:0] req1_wdata;
  logic        rsp1_valid;
  logic [31:0] rsp1_rdata;
  logic        clr_start, clr_busy, clr_done;
  logic        mem_w_en;
  logic [31:0] mem_w_data;
  logic [5:0]  mem_addr;
  logic [31:0] mem_r_data;

  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_file_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_w_en(mem_w_en), .mem_w_data(mem_w_data), .mem_addr(mem_addr),
    .mem_r_data(mem_r_data)
  );

  always @(posedge clk) if (mem_w_en) mem[mem_addr] <= mem_w_data;
  assign mem_r_data = mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Responses are popped against the queues half a cycle after they are launched.
  always @(negedge clk) begin
    #2;
    if (rsp0_valid === 1'b1) begin
      if (q0.size() == 0) check("rsp0_unexpected", {31'b0, rsp0_valid}, 32'd0);
      else check("rsp0_rdata", rsp0_rdata, q0.pop_front());
    end
    if (rsp1_valid === 1'b1) begin
      if (q1.size() == 0) check("rsp1_unexpected", {31'b0, rsp1_valid}, 32'd0);
      else check("rsp1_rdata", rsp1_rdata, q1.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic acc0(input logic we, input logic [5:0] addr, input logic [31:0] data);
    req0_valid = 1'b1; req0_we = we; req0_addr = addr; req0_wdata = data;
    #1;
    check("acc0_ready", {31'b0, req0_ready}, 32'd1);
    check("acc0_wen", {31'b0, mem_w_en}, {31'b0, we});
    if (we) ref_mem[addr] = data;
    else q0.push_back(ref_mem[addr]);
    tick();
    req0_valid = 1'b0;
  endtask

  task automatic acc1(input logic we, input logic [5:0] addr, input logic [31:0] data);
    req1_valid = 1'b1; req1_we = we; req1_addr = addr; req1_wdata = data;
    #1;
    check("acc1_ready", {31'b0, req1_ready}, 32'd1);
    check("acc1_wen", {31'b0, mem_w_en}, {31'b0, we});
    if (we) ref_mem[addr] = data;
    else q1.push_back(ref_mem[addr]);
    tick();
    req1_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clr_start = 1'b0;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
    @(negedge clk);
    tick();

    // Held in reset: no grants, no writes, registered outputs cleared.
    req0_valid = 1'b1; clr_start = 1'b1;
    #1;
    check("rst_ready0", {31'b0, req0_ready}, 32'd0);
    check("rst_wen", {31'b0, mem_w_en}, 32'd0);
    check("rst_busy", {31'b0, clr_busy}, 32'd0);
    check("rst_rsp0", {31'b0, rsp0_valid}, 32'd0);
    check("rst_rdata1", rsp1_rdata, 32'd0);
    check("rst_done", {31'b0, clr_done}, 32'd0);
    tick();
    req0_valid = 1'b0; clr_start = 1'b0; reset = 1'b0;

    // Port 0 write then read-back of the same address.
    acc0(1'b1, 6'd5, 32'hDEADBEEF);
    acc0(1'b0, 6'd5, 32'h0);
    tick();
    check("rsp0_pulse_end", {31'b0, rsp0_valid}, 32'd0);
    check("rsp1_idle", {31'b0, rsp1_valid}, 32'd0);

    // Preload, leaving last grant on port 1 so port 0 wins first contention.
    acc0(1'b1, 6'd1, 32'hA1A1_0001);
    acc1(1'b1, 6'd2, 32'hB2B2_0002);
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 6'd1;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 6'd2;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("rr_ready0", {31'b0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_ready1", {31'b0, req1_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
      check("rr_addr", {26'b0, mem_addr}, (i % 2 == 0) ? 32'd1 : 32'd2);
      if (i % 2 == 0) q0.push_back(ref_mem[1]);
      else q1.push_back(ref_mem[2]);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    // Port 1 back-to-back writes at the top of the address range.
    for (int i = 0; i < 4; i++) acc1(1'b1, 6'(60 + i), 32'h1000_0000 + 32'(i));
    acc1(1'b0, 6'd63, 32'h0);
    tick();

    // Full clear sweep requested while port 0 is waiting.
    acc0(1'b1, 6'd0, 32'h1111_1111);
    acc0(1'b1, 6'd63, 32'h6363_6363);
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 6'd0; clr_start = 1'b1;
    #1;
    check("clr_start_ready0", {31'b0, req0_ready}, 32'd0);
    check("clr_start_wen", {31'b0, mem_w_en}, 32'd0);
    tick();
    clr_start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      #1;
      check("clr_busy", {31'b0, clr_busy}, 32'd1);
      check("clr_ready0", {31'b0, req0_ready}, 32'd0);
      check("clr_wen", {31'b0, mem_w_en}, 32'd1);
      check("clr_addr", {26'b0, mem_addr}, 32'(i));
      check("clr_wdata", mem_w_data, 32'd0);
      check("clr_done_early", {31'b0, clr_done}, 32'd0);
      ref_mem[i] = 32'd0;
      tick();
    end
    #1;
    check("clr_done_pulse", {31'b0, clr_done}, 32'd1);
    check("clr_done_busy", {31'b0, clr_busy}, 32'd0);
    check("clr_done_grant0", {31'b0, req0_ready}, 32'd1);
    q0.push_back(ref_mem[0]);
    tick();
    req0_valid = 1'b0;
    check("clr_done_end", {31'b0, clr_done}, 32'd0);
    acc0(1'b0, 6'd63, 32'h0);
    tick();

    // Second start mid-sweep must neither restart nor extend it.
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i == 10) clr_start = 1'b1;
      #1;
      check("clr2_busy", {31'b0, clr_busy}, 32'd1);
      check("clr2_addr", {26'b0, mem_addr}, 32'(i));
      tick();
      clr_start = 1'b0;
    end
    check("clr2_done", {31'b0, clr_done}, 32'd1);
    tick();
    check("clr2_done_end", {31'b0, clr_done}, 32'd0);
    check("clr2_busy_end", {31'b0, clr_busy}, 32'd0);
    tick();
    check("clr2_done_once", {31'b0, clr_done}, 32'd0);

    // Reset during a sweep aborts it and leaves the tail uncleared.
    acc0(1'b1, 6'd30, 32'h3030_3030);
    acc0(1'b1, 6'd5, 32'h0505_0505);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ref_mem[i] = 32'd0;
      tick();
    end
    #1;
    check("abort_addr", {26'b0, mem_addr}, 32'd20);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("abort_busy", {31'b0, clr_busy}, 32'd0);
    check("abort_done", {31'b0, clr_done}, 32'd0);
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 6'd30;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 6'd5;
    #1;
    check("abort_grant0", {31'b0, req0_ready}, 32'd1);
    check("abort_ready1", {31'b0, req1_ready}, 32'd0);
    q0.push_back(ref_mem[30]);
    tick();
    req0_valid = 1'b0;
    #1;
    check("abort_grant1", {31'b0, req1_ready}, 32'd1);
    q1.push_back(ref_mem[5]);
    tick();
    req1_valid = 1'b0;
    tick();
    tick();

    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_file_arbiter.md
Name: mem_file_arbiter

Overview:
- Arbitrates the single-port 64x32 data memory (one address, sync write, combinational read) between two requesters: port 0 (CPU load/store) and port 1 (loader/debug).
- Round-robin grant; at most one access per cycle.
- Contains a clear sequencer that zero-fills the whole memory on command while stalling both requesters.
- Sits between the requesters and the memory's w_en / w_data / addr / r_data pins.

Parameters:
- N_WORDS, 64, memory depth in words; the clear sweep covers 0..N_WORDS-1.
- ADDR_W, 6, address width; must equal clog2(N_WORDS).
- DATA_W, 32, data word width.

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  synchronous, active-high
- req0_valid  in  1  port 0 request pending
- req0_ready  out  1  port 0 accepted this cycle
- req0_we  in  1  1 = write, 0 = read
- req0_addr  in  ADDR_W  port 0 word address
- req0_wdata  in  DATA_W  port 0 write data
- rsp0_valid  out  1  port 0 read data valid (1-cycle pulse)
- rsp0_rdata  out  DATA_W  port 0 read data
- req1_valid / req1_ready / req1_we / req1_addr / req1_wdata / rsp1_valid / rsp1_rdata: same as port 0, for port 1
- clr_start  in  1  start clear sweep (sampled in IDLE only)
- clr_busy  out  1  high while in CLEAR
- clr_done  out  1  1-cycle pulse after the last clear write
- mem_w_en  out  1  memory write enable
- mem_w_data  out  DATA_W  memory write data
- mem_addr  out  ADDR_W  memory address
- mem_r_data  in  DATA_W  memory combinational read data

Behaviour:
- Reset: the block is held in reset and reset values apply on the edge where reset is sampled high.
  - State := IDLE, clear counter := 0, last_grant := 1 (so port 0 wins first contention).
  - rsp*_valid := 0, rsp*_rdata := 0, clr_done := 0.
  - While reset is high: req*_ready = 0, mem_w_en = 0, clr_busy = 0.
- FSM states: IDLE, CLEAR.
- IDLE, grant (combinational):
  - clr_start = 1 → no grant this cycle, both readies 0; next state CLEAR.
  - Else only one valid → grant it.
  - Both valid → grant the port != last_grant.
  - last_grant updates on every accepted transfer.
- Accept = valid && ready.
  - mem_addr = granted addr; mem_w_data = granted wdata; mem_w_en = granted we.
  - No grant → mem_w_en = 0, mem_addr = 0, mem_w_data = 0.
- Reads: mem_r_data is sampled at the accept edge.
  - rsp_valid of the accepting port is high exactly the next cycle; rsp_rdata holds the data.
  - rsp_rdata holds its value until the next read response on that port.
  - Writes generate no response; the write completes at the accept edge.
- Back-to-back accepts on the same port are allowed every cycle when uncontended. Read-after-write to the same address in the next cycle returns the new data.
- CLEAR:
  - clr_busy = 1, both readies = 0, mem_w_en = 1, mem_addr = counter, mem_w_data = 0.
  - Counter increments every cycle.
  - After the write at N_WORDS-1: counter := 0, state := IDLE, clr_done = 1 for that next cycle.
  - Sweep length is exactly N_WORDS cycles.
  - clr_start during CLEAR is ignored (no restart, no extension).
- clr_done cycle is IDLE: requests may be granted in that same cycle.
- Reset mid-CLEAR: abort immediately; memory is partially cleared; clr_done is not pulsed.
- Requesters must hold valid/addr/we/wdata stable until ready. Dropping valid before ready is legal and simply withdraws the request.
- No address range checking; addresses wrap naturally at ADDR_W bits.

Test Plan:
- Reset, then port 0 writes 0xDEADBEEF to address 5, then reads address 5 → req0_ready high in both cycles; rsp0_valid pulses one cycle after the read accept with rsp0_rdata = 0xDEADBEEF; rsp1_valid stays 0.
- Both ports hold a read valid continuously (port 0 addr 1, port 1 addr 2) for 6 cycles → grants alternate 0,1,0,1,0,1 starting with port 0; each port gets 3 responses with the correct data.
- Port 1 alone issues 4 back-to-back writes to addresses 60..63 → req1_ready high in all 4 cycles; mem_w_en high for 4 cycles; a later read of 63 returns the written value.
- Preload addresses 0 and 63 with nonzero data, pulse clr_start while req0_valid is high:
  - readies are 0 for 65 cycles (start cycle + 64 CLEAR cycles); clr_busy is high for 64 cycles; mem_addr steps 0..63.
  - clr_done pulses once; req0 is granted in the clr_done cycle.
  - Reads of 0 and 63 return 0.
- Pulse clr_start again at clear cycle 10 → sweep still ends after 64 total cycles with exactly one clr_done.
- Assert reset at clear cycle 20 → next cycle clr_busy = 0 and clr_done = 0; address 30 keeps its preloaded value; a port 0 read after reset releases is granted immediately.
